v_hier_vecdrv: RTL and testbench

V_HIER_VECDRV -- requirements
Module: v_hier_vecdrv

---
 rtl/v_hier_pkg.sv | 16 +
 rtl/v_hier_vecdrv_if.sv | 22 ++
 rtl/v_hier_latcnt.sv | 26 ++
 rtl/v_hier_vecdrv.sv | 114 +++++++++++
 tb/tb_v_hier_vecdrv.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/v_hier_pkg.sv
// Shared types and parameter limits for the v_hier vector driver.
package v_hier_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned NUM_VEC_MIN = 1;
    localparam int unsigned NUM_VEC_MAX = 256;

endpackage

// File: rtl/v_hier_vecdrv_if.sv
// Response beat channel: {driven avec, sampled qvec} with valid/ready handshake.
interface v_hier_vecdrv_if #(
    parameter int unsigned WIDTH = 4
);

    logic               resp_valid;
    logic               resp_ready;
    logic [2*WIDTH-1:0] resp_data;

    modport master (
        output resp_valid,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        output resp_ready
    );

endinterface

// File: rtl/v_hier_latcnt.sv
// 4-bit load/increment counter flagging when the count equals term_val.
module v_hier_latcnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    input  logic [3:0] term_val,
    output logic       tc
);

    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (inc) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign tc = (count_q == term_val);

endmodule

// File: rtl/v_hier_vecdrv.sv
// Drives an incrementing vector sequence, samples the returned response after a
// fixed latency and hands {avec, qvec} out as handshaked beats with a checksum.
module v_hier_vecdrv
    import v_hier_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned NUM_VEC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] avec,
    input  logic [WIDTH-1:0] qvec,
    v_hier_vecdrv_if.master  resp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] csum
);

    localparam int unsigned CntW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam logic [CntW-1:0] LastVec = CntW'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] avec_q, avec_d;
    logic [WIDTH-1:0] qsamp_q, qsamp_d;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic [CntW-1:0]  vcnt_q, vcnt_d;
    logic             lat_load, lat_inc, lat_tc;

    // Terminal count at LATENCY-1 gives exactly LATENCY cycles spent in DRIVE.
    v_hier_latcnt u_latcnt (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .load_val (4'd0),
        .inc      (lat_inc),
        .term_val (4'(LATENCY - 1)),
        .tc       (lat_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            avec_q  <= '0;
            qsamp_q <= '0;
            csum_q  <= '0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            avec_q  <= avec_d;
            qsamp_q <= qsamp_d;
            csum_q  <= csum_d;
            vcnt_q  <= vcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        avec_d   = avec_q;
        qsamp_d  = qsamp_q;
        csum_d   = csum_q;
        vcnt_d   = vcnt_q;
        lat_load = 1'b0;
        lat_inc  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    avec_d   = seed;
                    vcnt_d   = '0;
                    csum_d   = '0;
                    lat_load = 1'b1;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                lat_inc = 1'b1;
                if (lat_tc) begin
                    qsamp_d = qvec;
                    state_d = StSample;
                end
            end
            StSample: begin
                if (resp.resp_ready) begin
                    csum_d = {csum_q[WIDTH-2:0], csum_q[WIDTH-1]} ^ qsamp_q;
                    if (vcnt_q == LastVec) begin
                        state_d = StDone;
                    end else begin
                        avec_d   = avec_q + WIDTH'(1);
                        vcnt_d   = vcnt_q + CntW'(1);
                        lat_load = 1'b1;
                        state_d  = StDrive;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // All outputs come straight from state registers; resp_ready never reaches resp_valid.
    assign resp.resp_valid = (state_q == StSample);
    assign resp.resp_data  = {avec_q, qsamp_q};
    assign avec            = avec_q;
    assign csum            = csum_q;
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);

endmodule

// File: tb/tb_v_hier_vecdrv.sv
// Directed bench: a 4-vector instance with qvec = ~avec and a 1-vector instance.
module tb_v_hier_vecdrv;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [3:0] seed_a, seed_b;
    logic [3:0] avec_a, avec_b, qvec_a, qvec_b;
    logic [3:0] csum_a, csum_b;
    logic       busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;

    v_hier_vecdrv_if #(.WIDTH(4)) ifa ();
    v_hier_vecdrv_if #(.WIDTH(4)) ifb ();

    assign qvec_a = ~avec_a;
    assign qvec_b = 4'h5;

    v_hier_vecdrv #(.WIDTH(4), .LATENCY(2), .NUM_VEC(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .start (start_a),
        .seed  (seed_a),
        .avec  (avec_a),
        .qvec  (qvec_a),
        .resp  (ifa.master),
        .busy  (busy_a),
        .done  (done_a),
        .csum  (csum_a)
    );

    v_hier_vecdrv #(.WIDTH(4), .LATENCY(2), .NUM_VEC(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .start (start_b),
        .seed  (seed_b),
        .avec  (avec_b),
        .qvec  (qvec_b),
        .resp  (ifb.master),
        .busy  (busy_b),
        .done  (done_b),
        .csum  (csum_b)
    );

    always #5 clk = ~clk;

    // Transfer/done monitor for instance A, sampling pre-edge values.
    int         cyc = 0;
    int         beats = 0;
    int         dones = 0;
    logic [3:0] beat_avec [64];
    int         beat_cyc  [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && ifa.resp_valid && ifa.resp_ready) begin
            if (beats < 64) begin
                beat_avec[beats] <= avec_a;
                beat_cyc[beats]  <= cyc;
            end
            beats <= beats + 1;
        end
        if (done_a) dones <= dones + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] csum_step(input logic [3:0] c, input logic [3:0] q);
        return {c[2:0], c[3]} ^ q;
    endfunction

    // sel: 0 = A valid, 1 = A done, 2 = B valid
    task automatic wait_for(input int sel, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if ((sel == 0 && ifa.resp_valid) || (sel == 1 && done_a) ||
                (sel == 2 && ifb.resp_valid)) begin
                hit = 1'b1;
                break;
            end
            step(1);
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    function automatic logic [3:0] run_csum(input logic [3:0] seed);
        logic [3:0] c = 4'h0;
        logic [3:0] a = seed;
        for (int i = 0; i < 4; i++) begin
            c = csum_step(c, ~a);
            a = a + 4'h1;
        end
        return c;
    endfunction

    int b0, d0;

    initial begin
        reset = 1'b1;
        start_a = 1'b0;  start_b = 1'b0;
        seed_a  = 4'h0;  seed_b  = 4'h0;
        ifa.resp_ready = 1'b0;
        ifb.resp_ready = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);

        check_eq("rst_avec",  32'(avec_a),         32'h0);
        check_eq("rst_valid", 32'(ifa.resp_valid), 32'h0);
        check_eq("rst_data",  32'(ifa.resp_data),  32'h0);
        check_eq("rst_busy",  32'(busy_a),         32'h0);
        check_eq("rst_done",  32'(done_a),         32'h0);
        check_eq("rst_csum",  32'(csum_a),         32'h0);

        // Full run with ready high; a start pulse during DRIVE must be ignored.
        b0 = beats; d0 = dones;
        ifa.resp_ready = 1'b1;
        seed_a = 4'hE; start_a = 1'b1;
        step(1);
        check_eq("run1_busy", 32'(busy_a), 32'h1);
        check_eq("run1_avec0", 32'(avec_a), 32'hE);
        step(1);
        start_a = 1'b0;
        wait_for(1, "run1_done_seen");
        check_eq("run1_beats", 32'(beats - b0), 32'd4);
        check_eq("run1_csum",  32'(csum_a), 32'(run_csum(4'hE)));
        check_eq("run1_avec_final", 32'(avec_a), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("run1_beat%0d_avec", i), 32'(beat_avec[b0 + i]),
                     32'((4'hE + 4'(i)) & 4'hF));
        end
        for (int i = 1; i < 4; i++) begin
            check_eq($sformatf("run1_gap%0d", i), 32'(beat_cyc[b0 + i] - beat_cyc[b0 + i - 1]),
                     32'd3);
        end
        step(1);
        check_eq("run1_done_pulse", 32'(done_a), 32'h0);
        check_eq("run1_idle", 32'(busy_a), 32'h0);
        check_eq("run1_ndone", 32'(dones - d0), 32'd1);
        check_eq("run1_hold_csum", 32'(csum_a), 32'(run_csum(4'hE)));

        // Stall in first SAMPLE.
        ifa.resp_ready = 1'b0;
        seed_a = 4'hE; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_for(0, "stall_valid_seen");
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(ifa.resp_valid), 32'h1);
            check_eq("stall_data",  32'(ifa.resp_data),  32'hE1);
            check_eq("stall_avec",  32'(avec_a),         32'hE);
            check_eq("stall_csum",  32'(csum_a),         32'h0);
            step(1);
        end
        ifa.resp_ready = 1'b1;
        wait_for(1, "stall_done_seen");
        check_eq("stall_csum_final", 32'(csum_a), 32'(run_csum(4'hE)));
        step(1);

        // Reset while vector 1 is in SAMPLE with ready asserted.
        ifa.resp_ready = 1'b0;
        seed_a = 4'hE; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_for(0, "rst_run_v0");
        ifa.resp_ready = 1'b1;
        step(1);
        ifa.resp_ready = 1'b0;
        wait_for(0, "rst_run_v1");
        check_eq("rst_run_v1_avec", 32'(avec_a), 32'hF);
        d0 = dones;
        ifa.resp_ready = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("mid_rst_avec",  32'(avec_a),         32'h0);
        check_eq("mid_rst_valid", 32'(ifa.resp_valid), 32'h0);
        check_eq("mid_rst_data",  32'(ifa.resp_data),  32'h0);
        check_eq("mid_rst_busy",  32'(busy_a),         32'h0);
        check_eq("mid_rst_csum",  32'(csum_a),         32'h0);
        step(10);
        check_eq("mid_rst_nodone", 32'(dones - d0), 32'd0);
        check_eq("mid_rst_idle",   32'(busy_a),     32'h0);
        seed_a = 4'h0; start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_for(1, "seed0_done_seen");
        check_eq("seed0_avec_final", 32'(avec_a), 32'h3);
        check_eq("seed0_csum", 32'(csum_a), 32'(run_csum(4'h0)));
        step(1);

        // Reset beats a simultaneous start.
        reset = 1'b1; start_a = 1'b1;
        step(1);
        check_eq("rst_start_busy", 32'(busy_a), 32'h0);
        reset = 1'b0; start_a = 1'b0;
        step(1);
        check_eq("rst_start_idle", 32'(busy_a), 32'h0);

        // Single-vector instance.
        ifb.resp_ready = 1'b1;
        seed_b = 4'h7; start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        wait_for(2, "one_valid_seen");
        check_eq("one_data", 32'(ifb.resp_data), 32'h75);
        step(1);
        check_eq("one_done", 32'(done_b), 32'h1);
        check_eq("one_csum", 32'(csum_b), 32'h5);
        check_eq("one_avec", 32'(avec_b), 32'h7);
        check_eq("one_valid_drop", 32'(ifb.resp_valid), 32'h0);
        step(1);
        check_eq("one_done_pulse", 32'(done_b), 32'h0);
        check_eq("one_idle", 32'(busy_b), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
